// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero, optional write-to-read bypass,
// a sequential clear started by RST, and a trigger/observe register pair.
module regfile_mp #(
    parameter int A_WIDTH  = 5,
    parameter int D_WIDTH  = 32,
    parameter int N_READ   = 2,
    parameter int N_WRITE  = 2,
    parameter int BYPASS   = 1,
    parameter int TRIG_REG = 5,
    parameter int OUT_REG  = 10
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        trigger,
    input  logic [N_WRITE-1:0]          WE,
    input  logic [N_WRITE*A_WIDTH-1:0]  WA,
    input  logic [N_WRITE*D_WIDTH-1:0]  WD,
    input  logic [N_READ*A_WIDTH-1:0]   RA,
    output logic [N_READ*D_WIDTH-1:0]   RD,
    output logic [D_WIDTH-1:0]          a0,
    output logic                        busy
);

    localparam int                 DEPTH     = 2 ** A_WIDTH;
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);
    localparam logic [A_WIDTH-1:0] TRIG_ADDR = A_WIDTH'(TRIG_REG);
    localparam logic [A_WIDTH-1:0] OUT_ADDR  = A_WIDTH'(OUT_REG);
    localparam bit                 TRIG_EN   = (TRIG_REG != 0);
    localparam bit                 FWD_EN    = (BYPASS != 0);

    typedef enum logic {
        READY,
        CLEAR
    } state_t;

    state_t               state = READY;
    state_t               state_next;
    logic [A_WIDTH-1:0]   ptr = '0;
    logic [A_WIDTH-1:0]   ptr_next;
    logic [D_WIDTH-1:0]   regs [DEPTH] = '{default: '0};

    logic [A_WIDTH-1:0]   wa   [N_WRITE];
    logic [D_WIDTH-1:0]   wd   [N_WRITE];
    logic [N_WRITE-1:0]   we_ok;

    // Unpack the write ports; a write to x0 is dropped before it reaches the array.
    always_comb begin
        for (int p = 0; p < N_WRITE; p++) begin
            wa[p]    = WA[p*A_WIDTH +: A_WIDTH];
            wd[p]    = WD[p*D_WIDTH +: D_WIDTH];
            we_ok[p] = WE[p] && (wa[p] != '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        if (state == CLEAR) begin
            ptr_next = ptr + 1'b1;
            if (ptr == LAST_ADDR) begin
                state_next = READY;
            end
        end
    end

    // Later loop iterations override earlier ones, so the highest port wins and trigger beats all.
    always_ff @(posedge CLK) begin
        if (RST) begin
            regs[0] <= '0;
        end else if (state == CLEAR) begin
            regs[ptr] <= '0;
        end else begin
            for (int p = 0; p < N_WRITE; p++) begin
                if (we_ok[p]) begin
                    regs[wa[p]] <= wd[p];
                end
            end
            if (TRIG_EN && trigger) begin
                regs[TRIG_ADDR] <= D_WIDTH'(1);
            end
        end
    end

    function automatic logic [D_WIDTH-1:0] read_value(input logic [A_WIDTH-1:0] addr);
        logic [D_WIDTH-1:0] v;
        v = regs[addr];
        if (FWD_EN) begin
            for (int p = 0; p < N_WRITE; p++) begin
                if (we_ok[p] && (wa[p] == addr)) begin
                    v = wd[p];
                end
            end
            if (TRIG_EN && trigger && (addr == TRIG_ADDR)) begin
                v = D_WIDTH'(1);
            end
        end
        if (addr == '0 || state == CLEAR) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        RD = '0;
        for (int q = 0; q < N_READ; q++) begin
            RD[q*D_WIDTH +: D_WIDTH] = read_value(RA[q*A_WIDTH +: A_WIDTH]);
        end
        a0 = read_value(OUT_ADDR);
    end

    assign busy = (state == CLEAR);

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the RISC-V core: configurable read and write port counts, optional write-to-read bypass, a sequential hardware clear after reset, and a generalised trigger/observe register pair. It replaces the fixed 2-read/1-write register file in the decode/writeback path. It is sized for a dual-issue or forwarding-heavy pipeline without changing register semantics (x0 hardwired to zero).

## Interface

Parameters:
- A_WIDTH, 5, address width; depth = 2**A_WIDTH registers.
- D_WIDTH, 32, data width.
- N_READ, 2, number of read ports (≥1).
- N_WRITE, 2, number of write ports (≥1).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value only.
- TRIG_REG, 5, register set to 1 by `trigger`.
- OUT_REG, 10, register mirrored on `a0`.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RST  in  1  synchronous, active-high reset; starts the clear sequence.
- trigger  in  1  set REG[TRIG_REG] := 1 at next edge.
- WE  in  N_WRITE  per-port write enable.
- WA  in  N_WRITE*A_WIDTH  write addresses, port p at bits [p*A_WIDTH +: A_WIDTH].
- WD  in  N_WRITE*D_WIDTH  write data, packed likewise.
- RA  in  N_READ*A_WIDTH  read addresses, packed likewise.
- RD  out  N_READ*D_WIDTH  read data, combinational, packed likewise.
- a0  out  D_WIDTH  combinational view of REG[OUT_REG].
- busy  out  1  high while clear sequence runs; core must stall.

## Operation

- States: READY, CLEAR. Clear pointer `ptr`, A_WIDTH bits.
- RST=1 at an edge: state := CLEAR, ptr := 0, REG[0] := 0. Held RST keeps ptr at 0.
- CLEAR, RST=0: REG[ptr] := 0; ptr := ptr+1; when ptr = 2**A_WIDTH-1 the write clears the last register and state := READY (ptr wraps to 0).
- RST mid-clear restarts from ptr 0.
- In CLEAR: all writes and trigger are ignored; RD all ports = 0; a0 = 0; busy = 1.
- READY writes: port p writes REG[WA[p]] := WD[p] when WE[p]=1 and WA[p]≠0. Writes to address 0 are discarded.
- Same-address conflict: the highest-indexed enabled port wins.
- trigger=1 in READY: REG[TRIG_REG] := 1, overriding any port write to TRIG_REG in that cycle. If TRIG_REG=0, trigger has no effect.
- Reads: RD[q] = REG[RA[q]]; address 0 always reads 0.
- BYPASS=1: if any port p has WE[p]=1, WA[p]=RA[q]≠0, RD[q] = WD of highest such p. A trigger targeting RA[q] forwards 1 and takes precedence. BYPASS=0: stored value only.
- a0 follows the same read rules as a read port addressed OUT_REG, including bypass.
- Simulation start: all registers 0, state READY, busy 0. Functional init is via RST.

## Timing

- Output values after an RST edge: busy=1, RD=0, a0=0.
- Clear latency: busy falls after the 2**A_WIDTH-th edge that samples RST=0, counting from the first such edge (32 edges at default). The first write is accepted at the edge after busy falls.
- Write latency: 1 edge, stored. Read latency: 0 (combinational). With BYPASS=1, a write is visible on RD in the same cycle.
- busy is registered (a function of state only), never combinational from RST.

## Test plan

- Reset clear: preload x1..x31 = 0xFFFF_FFFF, pulse RST 1 cycle -> busy=1 for exactly 32 cycles, RD=0 throughout; afterwards all registers read 0.
- Dual write conflict: WE=2'b11, WA0=WA1=7, WD0=0x11, WD1=0x22 -> next cycle x7 = 0x22. With WA1=0: x7=0x11, x0 stays 0.
- Bypass: BYPASS=1, WE0=1, WA0=3, WD0=0xABCD, RA0=3 same cycle -> RD0=0xABCD before the edge. BYPASS=0 build -> old x3 value.
- Trigger: trigger=1 together with port-0 write of 0x55 to x5 -> x5 = 1. Write 0x99 to x10 -> a0 = 0x99 the next cycle (same cycle with bypass).
- Reset mid-clear: RST asserted at clear cycle 10, then released -> busy stays high 32 further cycles. Writes during busy (x4=0x1234) are lost; x4=0.
- Busy gating: trigger and WE during CLEAR -> no register changes, a0=0.
